// File: rtl/fft8_pkg.sv
// Shared constants, state encoding and delay-line payload for the 8-point FFT sequencer.
package fft8_pkg;
    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int NBFLY = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        FLUSH,
        DONE
    } state_t;

    typedef struct packed {
        logic             vld;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [1:0]       s;
    } bfly_t;
endpackage

// File: rtl/fft8_bfly_idx.sv
// Maps (stage, butterfly) to the in-place DIT operand pair and twiddle exponent.
module fft8_bfly_idx
    import fft8_pkg::*;
(
    input  logic [1:0]       s,
    input  logic [1:0]       k,
    output logic [LOG2N-1:0] a,
    output logic [LOG2N-1:0] b,
    output logic [LOG2N-1:0] tw_index
);
    logic [2:0] kx, span, grp, pos;

    always_comb begin
        kx       = {1'b0, k};
        span     = 3'd1 << s;
        grp      = kx >> s;
        pos      = kx & (span - 3'd1);
        a        = ((grp * span) << 1) + pos;
        b        = a + span;
        tw_index = pos << (2'd2 - s);
    end
endmodule

// File: rtl/fft8_addr_gen.sv
// Stage/butterfly sequencer for the in-place radix-2 8-point FFT: drives the twiddle ROM,
// then presents the operand pair aligned with the ROM's registered output.
module fft8_addr_gen
    import fft8_pkg::*;
#(
    parameter int TW_LAT    = 1,
    parameter int STAGE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       tw_en,
    output logic [2:0] tw_index,
    output logic       bfly_valid,
    output logic [2:0] addr_a,
    output logic [2:0] addr_b,
    output logic [1:0] stage,
    output logic       done
);
    state_t     state, state_nxt;
    logic [1:0] s_cnt, s_nxt, k_cnt, k_nxt;
    logic [7:0] w_cnt, w_nxt;
    logic [2:0] a_c, b_c, tw_c;
    bfly_t      bfly_c;
    bfly_t      bfly_p0;
    bfly_t      dly_p1 [TW_LAT];

    fft8_bfly_idx u_idx (
        .s        (s_cnt),
        .k        (k_cnt),
        .a        (a_c),
        .b        (b_c),
        .tw_index (tw_c)
    );

    always_comb begin
        state_nxt = state;
        s_nxt     = s_cnt;
        k_nxt     = k_cnt;
        w_nxt     = w_cnt;
        bfly_c    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    s_nxt     = '0;
                    k_nxt     = '0;
                end
            end
            ISSUE: begin
                bfly_c.vld = 1'b1;
                bfly_c.a   = a_c;
                bfly_c.b   = b_c;
                bfly_c.s   = s_cnt;
                w_nxt      = '0;
                if (k_cnt == 2'(NBFLY - 1)) begin
                    k_nxt = '0;
                    if (s_cnt == 2'(LOG2N - 1))
                        state_nxt = FLUSH;
                    else if (STAGE_GAP == 0)
                        s_nxt = s_cnt + 2'd1;
                    else
                        state_nxt = GAP;
                end else begin
                    k_nxt = k_cnt + 2'd1;
                end
            end
            GAP: begin
                if (w_cnt == 8'(STAGE_GAP - 1)) begin
                    state_nxt = ISSUE;
                    s_nxt     = s_cnt + 2'd1;
                end else begin
                    w_nxt = w_cnt + 8'd1;
                end
            end
            // Let the last ROM read drain before signalling completion.
            FLUSH: begin
                if (w_cnt == 8'(TW_LAT - 1))
                    state_nxt = DONE;
                else
                    w_nxt = w_cnt + 8'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s_cnt    <= '0;
            k_cnt    <= '0;
            w_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tw_index <= '0;
            bfly_p0  <= '0;
            for (int i = 0; i < TW_LAT; i++) dly_p1[i] <= '0;
        end else begin
            state <= state_nxt;
            s_cnt <= s_nxt;
            k_cnt <= k_nxt;
            w_cnt <= w_nxt;
            busy  <= (state != IDLE) && (state != DONE);
            done  <= (state == DONE);
            if (state == ISSUE) tw_index <= tw_c;
            // p0: ROM request issued; p1 line: mirrors the ROM read latency
            bfly_p0   <= bfly_c;
            dly_p1[0] <= bfly_p0;
            for (int i = 1; i < TW_LAT; i++) dly_p1[i] <= dly_p1[i-1];
        end
    end

    assign tw_en      = bfly_p0.vld;
    assign bfly_valid = dly_p1[TW_LAT-1].vld;
    assign addr_a     = dly_p1[TW_LAT-1].a;
    assign addr_b     = dly_p1[TW_LAT-1].b;
    assign stage      = dly_p1[TW_LAT-1].s;
endmodule
